// File: rtl/msu_track_server.sv
// msu_track_server: host-side MSU-1 track server.
// Issues track handshakes toward the host, pairs streamed PCM words into
// stereo frames in a small FIFO and pops one frame per 44.1 kHz strobe.
module msu_track_server #(
    parameter int FIFO_AW = 4,
    parameter int UFLOW_W = 8
) (
    input  logic               mclk,
    input  logic               rst,
    input  logic [15:0]        track_num,
    input  logic               track_req,
    input  logic               play,
    input  logic               repeat_en,
    input  logic               sample_ce,
    output logic [15:0]        host_track,
    output logic               host_req,
    output logic               host_loop,
    input  logic               host_ack,
    input  logic               host_missing,
    input  logic               host_wr,
    input  logic [15:0]        host_data,
    input  logic               host_eot,
    output logic               host_ready,
    output logic [15:0]        audio_l,
    output logic [15:0]        audio_r,
    output logic               busy,
    output logic               missing,
    output logic               playing,
    output logic [UFLOW_W-1:0] underflow_cnt
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]         state;
    logic               req_gap;
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;
    logic [FIFO_AW:0]   occ;
    logic [31:0]        fifo_mem [DEPTH];
    logic               half;
    logic signed [15:0] l_hold;
    logic signed [15:0] audio_l_p1;
    logic signed [15:0] audio_r_p1;

    logic fifo_empty;
    logic fifo_full;
    logic feeding;
    logic accept_wr;
    logic push;
    logic play_ok;
    logic pop;

    // Saturating increment for the starvation counter.
    function automatic logic [UFLOW_W-1:0] sat_inc(input logic [UFLOW_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign occ        = wr_ptr - rd_ptr;
    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == (FIFO_AW + 1)'(DEPTH));
    // A loop restart keeps playing the frames already queued.
    assign feeding    = (state == S_STREAM) || (state == S_END) || ((state == S_REQ) && host_loop);
    // A new track request flushes the FIFO, which overrides any write or pop.
    assign accept_wr  = host_wr && ((state == S_STREAM) || (state == S_END)) && !fifo_full && !track_req;
    assign push       = accept_wr && half;
    assign play_ok    = sample_ce && play && feeding;
    assign pop        = play_ok && !fifo_empty && !track_req;

    // Track handshake FSM toward the host.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_gap    <= 1'b0;
            host_track <= '0;
            host_req   <= 1'b0;
            host_loop  <= 1'b0;
            busy       <= 1'b0;
            missing    <= 1'b0;
        end else if (track_req) begin
            host_track <= track_num;
            missing    <= 1'b0;
            busy       <= 1'b1;
            host_loop  <= 1'b0;
            state      <= S_REQ;
            // Aborting a live operation inserts a one-cycle low on host_req
            // so the host always sees a fresh rising edge.
            if ((state == S_IDLE) || (state == S_END)) begin
                host_req <= 1'b1;
                req_gap  <= 1'b0;
            end else begin
                host_req <= 1'b0;
                req_gap  <= 1'b1;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (req_gap) begin
                        host_req <= 1'b1;
                        req_gap  <= 1'b0;
                    end else if (host_ack) begin
                        host_req  <= 1'b0;
                        host_loop <= 1'b0;
                        busy      <= 1'b0;
                        if (host_missing) begin
                            missing <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            state   <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (host_eot) state <= S_END;
                end
                S_END: begin
                    if (repeat_en) begin
                        host_req  <= 1'b1;
                        host_loop <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO pointers and L/R pairing flag.
    always_ff @(posedge mclk) begin
        if (rst || track_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            half   <= 1'b0;
        end else begin
            if (accept_wr) begin
                half <= !half;
                if (half) wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Frame storage and held left word; pure data, no reset needed.
    always_ff @(posedge mclk) begin
        if (accept_wr && !half) l_hold <= host_data;
        if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {l_hold, host_data};
    end

    // ---- stage p1: frame output and starvation counting ----
    always_ff @(posedge mclk) begin
        if (rst) begin
            audio_l_p1    <= '0;
            audio_r_p1    <= '0;
            underflow_cnt <= '0;
        end else begin
            if (track_req) underflow_cnt <= '0;
            else if (play_ok && fifo_empty) underflow_cnt <= sat_inc(underflow_cnt);
            if (sample_ce) begin
                if (pop) begin
                    audio_l_p1 <= fifo_mem[rd_ptr[FIFO_AW-1:0]][31:16];
                    audio_r_p1 <= fifo_mem[rd_ptr[FIFO_AW-1:0]][15:0];
                end else begin
                    audio_l_p1 <= '0;
                    audio_r_p1 <= '0;
                end
            end
        end
    end

    // Registered status flags derived from current occupancy.
    always_ff @(posedge mclk) begin
        if (rst) begin
            host_ready <= 1'b1;
            playing    <= 1'b0;
        end else begin
            host_ready <= (occ <= (FIFO_AW + 1)'(DEPTH - 2));
            playing    <= feeding && play && !fifo_empty;
        end
    end

    assign audio_l = audio_l_p1;
    assign audio_r = audio_r_p1;

endmodule
